hs32_aict: RTL

- Advanced interrupt controller: one of the bus devices behind the hs32 address interconnect.
- Gathers 24 external interrupt lines into pending state and selects the highest-priority enabled request.
- Presents that request and its handler address to the hs32 core, holding it until the core acknowledges.
- Its 24-entry vector table and control register are programmed through the interconnect's single-device strobe/ack slave interface.

---
 rtl/hs32_aict_pkg.sv | 15 +
 rtl/hs32_aict_prio.sv | 20 ++
 rtl/hs32_aict.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/hs32_aict_pkg.sv
// Shared constants for the hs32 interrupt controller: table/control bit
// positions and the request FSM encoding.
package hs32_aict_pkg;
  localparam int ENT_EN        = 0;
  localparam int ENT_EDGE      = 1;
  localparam int ENT_VEC_LSB   = 2;
  localparam int CTRL_GE       = 0;
  localparam int CTRL_LAST_LSB = 24;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESENT = 2'd1,
    ST_RETRACT = 2'd2
  } state_t;
endpackage

// File: rtl/hs32_aict_prio.sv
// Combinational lowest-index-wins priority encoder.
module hs32_aict_prio #(
  parameter int N = 24
) (
  input  logic [N-1:0] i_req,
  output logic         o_valid,
  output logic [4:0]   o_idx
);
  // Scan downwards so the lowest set index is the last assignment.
  always_comb begin
    o_valid = 1'b0;
    o_idx   = 5'd0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_valid = 1'b1;
        o_idx   = 5'(i);
      end
    end
  end
endmodule

// File: rtl/hs32_aict.sv
// hs32 advanced interrupt controller: synchronises irq lines, tracks pending
// state, presents the highest-priority enabled request to the core.
module hs32_aict
  import hs32_aict_pkg::*;
#(
  parameter int NIRQ        = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stb,
  output logic            ack,
  input  logic [4:0]      addr,
  input  logic [31:0]     dtw,
  output logic [31:0]     dtr,
  input  logic            rw,
  input  logic [NIRQ-1:0] irq,
  output logic            int_req,
  output logic [31:0]     int_vec,
  output logic [4:0]      int_line,
  input  logic            int_ack,
  output logic [1:0]      dbg_state
);
  logic [NIRQ-1:0] r_sync [SYNC_STAGES];
  logic [NIRQ-1:0] r_sync_d;
  logic [NIRQ-1:0] r_pend;
  logic [31:0]     r_tab [NIRQ];
  logic            r_ge;
  logic [4:0]      r_last;
  logic            r_stb_q;
  logic            r_ack;
  logic [31:0]     r_dtr;
  logic [4:0]      r_line;
  logic [31:0]     r_vec;
  state_t          r_state;
  state_t          w_next;

  logic            w_acc, w_wr, w_wr_line, w_ack_hit, w_valid;
  logic [4:0]      w_idx;
  logic [31:0]     w_rdata;
  logic [NIRQ-1:0] w_en, w_mode, w_lvl, w_rise, w_set, w_clr, w_wr_sel, w_elig;

  // A held strobe is one access; a new one needs a low cycle first.
  assign w_acc     = stb & ~r_stb_q;
  assign w_wr      = w_acc & rw;
  assign w_wr_line = w_wr && (addr == r_line);
  assign w_ack_hit = (r_state == ST_PRESENT) && int_ack;

  always_comb begin
    w_rdata = '0;
    if (addr < 5'(NIRQ)) begin
      w_rdata = r_tab[addr];
    end else if (addr == 5'(NIRQ)) begin
      w_rdata[CTRL_GE]               = r_ge;
      w_rdata[CTRL_LAST_LSB +: 5]    = r_last;
    end
  end

  always_comb begin
    w_en     = '0;
    w_mode   = '0;
    w_wr_sel = '0;
    for (int n = 0; n < NIRQ; n++) begin
      w_en[n]     = r_tab[n][ENT_EN];
      w_mode[n]   = r_tab[n][ENT_EDGE];
      w_wr_sel[n] = w_wr && (addr == 5'(n));
    end
  end

  assign w_lvl  = r_sync[SYNC_STAGES-1];
  assign w_rise = w_lvl & ~r_sync_d;
  assign w_set  = (w_mode & w_rise) | (~w_mode & w_lvl);
  assign w_clr  = w_wr_sel | (w_ack_hit ? (NIRQ'(1) << r_line) : '0);
  assign w_elig = r_pend & w_en & {NIRQ{r_ge}};

  hs32_aict_prio #(.N(NIRQ)) u_prio (
    .i_req   (w_elig),
    .o_valid (w_valid),
    .o_idx   (w_idx)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
      r_sync_d <= '0;
      r_pend   <= '0;
    end else begin
      r_sync[0] <= irq;
      for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
      r_sync_d <= r_sync[SYNC_STAGES-1];
      // Set has priority over clear on the same line.
      r_pend   <= (r_pend & ~w_clr) | w_set;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int n = 0; n < NIRQ; n++) r_tab[n] <= '0;
      r_ge    <= 1'b0;
      r_last  <= '0;
      r_stb_q <= 1'b0;
      r_ack   <= 1'b0;
      r_dtr   <= '0;
      r_line  <= '0;
      r_vec   <= '0;
    end else begin
      r_stb_q <= stb;
      r_ack   <= w_acc;
      r_dtr   <= (w_acc && !rw) ? w_rdata : '0;
      if (w_wr && (addr < 5'(NIRQ))) r_tab[addr] <= dtw;
      if (w_wr && (addr == 5'(NIRQ))) r_ge <= dtw[CTRL_GE];
      if (w_ack_hit) r_last <= r_line;
      if ((r_state == ST_IDLE) && w_valid) begin
        r_line <= w_idx;
        r_vec  <= {r_tab[w_idx][31:ENT_VEC_LSB], 2'b00};
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (w_valid) w_next = ST_PRESENT;
      ST_PRESENT: begin
        if (int_ack)                          w_next = ST_IDLE;
        else if (w_wr_line || !w_elig[r_line]) w_next = ST_RETRACT;
      end
      ST_RETRACT: w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    int_req   = (r_state == ST_PRESENT);
    dbg_state = r_state;
    ack       = r_ack;
    dtr       = r_dtr;
    int_vec   = r_vec;
    int_line  = r_line;
  end
endmodule
